// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: bus widths and the
// 3-bit FSM state encodings.
package dmem_ctrl_pkg;

  localparam int RISCV_WORD_WIDTH = 32;
  localparam int RISCV_ADDR_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_CAPT   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } dmem_state_e;

  // Counter preload so that WAIT lasts exactly ws cycles.
  function automatic logic [3:0] wait_load(int unsigned ws);
    return (ws == 0) ? 4'd0 : 4'(ws - 1);
  endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; times the wait states.
module dmem_wait_cnt (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: LSU valid/ready port to single-port SRAM with wait states.
// Optional address window check enabled by defining DMEM_CTRL_RANGE_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a request, latches it on dmem_valid_i
// ACCESS | SRAM chip select cycle from the latched request
// CAPT   | SRAM read data captured (zero for writes)
// WAIT   | programmable wait states
// RESP   | one-cycle dmem_ready_o
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           dmem_valid_i,
  input  logic [RISCV_ADDR_WIDTH-1:0]    dmem_addr_i,
  input  logic [3:0]                     dmem_we_i,
  input  logic [RISCV_WORD_WIDTH-1:0]    dmem_wdata_i,
  output logic                           dmem_ready_o,
  output logic [RISCV_WORD_WIDTH-1:0]    dmem_rdata_o,
  output logic                           dmem_err_o,
  output logic                           sram_cs_o,
  output logic [3:0]                     sram_we_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
  output logic [31:0]                    sram_wdata_o,
  input  logic [31:0]                    sram_rdata_i
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS_LOAD = wait_load(WAIT_STATES);

  dmem_state_e                 state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [3:0]                  we_q, we_d;
  logic [RISCV_WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [RISCV_WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                        err_q, err_d;
  logic                        cnt_load, cnt_dec, cnt_zero;
  logic                        range_err;
  logic                        unused_addr;

`ifdef DMEM_CTRL_RANGE_CHECK_EN
  // 33-bit window limit so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
  assign range_err   = ({1'b0, dmem_addr_i} < {1'b0, BASE_ADDR}) ||
                       ({1'b0, dmem_addr_i} >= LIMIT);
  assign unused_addr = ^dmem_addr_i[1:0];
`else
  localparam logic [31:0] unused_base = BASE_ADDR;
  assign range_err   = 1'b0;
  assign unused_addr = ^{dmem_addr_i[RISCV_ADDR_WIDTH-1:AW+2], dmem_addr_i[1:0]};
`endif

  dmem_wait_cnt u_wait_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (WS_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dmem_valid_i) begin
          addr_d  = dmem_addr_i[AW+1:2];
          we_d    = dmem_we_i;
          wdata_d = dmem_wdata_i;
          if (range_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: state_d = ST_CAPT;
      ST_CAPT: begin
        rdata_d = (we_q == 4'd0) ? sram_rdata_i : '0;
        err_d   = 1'b0;
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
        end else begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem_ready_o = (state_q == ST_RESP);
    sram_cs_o    = (state_q == ST_ACCESS);
    sram_we_o    = (state_q == ST_ACCESS) ? we_q : 4'd0;
  end

  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign dmem_rdata_o = rdata_q;
  assign dmem_err_o   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: dut0 (WAIT_STATES=0, 1024 words at 0) and
// dut1 (WAIT_STATES=3, 16 words at 0x2000), each with a behavioural SRAM.
module tb_dmem_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ncs;
    int          saddr;
    logic [3:0]  swe;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  logic        v[2];
  logic [31:0] a[2];
  logic [3:0]  w[2];
  logic [31:0] wd[2];
  logic        rdy[2];
  logic [31:0] rd[2];
  logic        er[2];
  logic        cs[2];
  logic [3:0]  swe[2];
  logic [31:0] swd[2];
  logic [31:0] srd[2];
  logic [9:0]  sa0;
  logic [3:0]  sa1;

  dmem_ctrl #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .dmem_valid_i(v[0]), .dmem_addr_i(a[0]), .dmem_we_i(w[0]), .dmem_wdata_i(wd[0]),
    .dmem_ready_o(rdy[0]), .dmem_rdata_o(rd[0]), .dmem_err_o(er[0]),
    .sram_cs_o(cs[0]), .sram_we_o(swe[0]), .sram_addr_o(sa0), .sram_wdata_o(swd[0]),
    .sram_rdata_i(srd[0])
  );

  dmem_ctrl #(.BASE_ADDR(32'h0000_2000), .DEPTH_WORDS(16), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .dmem_valid_i(v[1]), .dmem_addr_i(a[1]), .dmem_we_i(w[1]), .dmem_wdata_i(wd[1]),
    .dmem_ready_o(rdy[1]), .dmem_rdata_o(rd[1]), .dmem_err_o(er[1]),
    .sram_cs_o(cs[1]), .sram_we_o(swe[1]), .sram_addr_o(sa1), .sram_wdata_o(swd[1]),
    .sram_rdata_i(srd[1])
  );

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [16];

  always @(posedge clk) begin
    if (cs[0]) begin
      for (int b = 0; b < 4; b++)
        if (swe[0][b]) mem0[sa0][b*8 +: 8] <= swd[0][b*8 +: 8];
      srd[0] <= mem0[sa0];
    end
    if (cs[1]) begin
      for (int b = 0; b < 4; b++)
        if (swe[1][b]) mem1[sa1][b*8 +: 8] <= swd[1][b*8 +: 8];
      srd[1] <= mem1[sa1];
    end
  end

  // Monitor: counts SRAM cycles per transaction and checks each response.
  int         ncs[2];
  int         cs_addr[2];
  logic [3:0] cs_we[2];
  logic       prev_rdy[2];

  task automatic check_resp(int d);
    exp_t e;
    int   lat;
    bit   empty;
    n_vec++;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_err++;
      $display("FAIL resp_unexpected dut%0d: ready with rdata %h but no request outstanding", d, rd[d]);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    lat = cyc - e.acc;
    if (rd[d] !== e.rdata || er[d] !== e.err || lat != e.lat || ncs[d] != e.ncs ||
        (e.ncs != 0 && (cs_addr[d] != e.saddr || cs_we[d] !== e.swe))) begin
      n_err++;
      $display("FAIL resp dut%0d: got rdata %h err %b lat %0d ncs %0d saddr %0d swe %h, required rdata %h err %b lat %0d ncs %0d saddr %0d swe %h",
               d, rd[d], er[d], lat, ncs[d], cs_addr[d], cs_we[d],
               e.rdata, e.err, e.lat, e.ncs, e.saddr, e.swe);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ncs[d]      = 0;
        prev_rdy[d] = 1'b0;
      end else begin
        if (cs[d]) begin
          ncs[d]++;
          cs_addr[d] = (d == 0) ? int'(sa0) : int'(sa1);
          cs_we[d]   = swe[d];
        end
        if (rdy[d]) begin
          n_vec++;
          if (prev_rdy[d]) begin
            n_err++;
            $display("FAIL ready_pulse dut%0d: ready high 2 cycles, required 1", d);
          end
          check_resp(d);
          ncs[d] = 0;
        end
        prev_rdy[d] = rdy[d];
      end
    end
  end

  // Issue one request, push its expectation, scramble inputs after acceptance.
  task automatic req(int d, logic [31:0] addr, logic [3:0] we, logic [31:0] wdata,
                     logic [31:0] erd, logic eerr, int elat, int encs, int esa, bit hold);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    v[d]  = 1'b1;
    a[d]  = addr;
    w[d]  = we;
    wd[d] = wdata;
    e = '{rdata: erd, err: eerr, lat: elat, ncs: encs, saddr: esa, swe: we, acc: cyc};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a[d]  = ~addr;
        w[d]  = ~we;
        wd[d] = ~wdata;
      end
      if (rdy[d]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout dut%0d addr %h: no ready within 40 cycles", d, addr);
    end
    if (!hold) v[d] = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    int sa;
    for (int d = 0; d < 2; d++) begin
      sa = (d == 0) ? int'(sa0) : int'(sa1);
      n_vec++;
      if (rdy[d] !== 1'b0 || cs[d] !== 1'b0 || swe[d] !== 4'd0 || rd[d] !== 32'd0 ||
          er[d] !== 1'b0 || swd[d] !== 32'd0 || sa != 0) begin
        n_err++;
        $display("FAIL %s dut%0d: got rdy %b cs %b we %h rdata %h err %b wdata %h addr %0d, required all 0",
                 tag, d, rdy[d], cs[d], swe[d], rd[d], er[d], swd[d], sa);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      v[d] = 1'b0; a[d] = '0; w[d] = '0; wd[d] = '0;
    end
    #3 chk_zero("reset_state");
    #9 rst_n = 1'b1;

    // dut0: zero wait states, 3-cycle latency
    req(0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 3, 1, 4, 1'b0);
    req(0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 4, 1'b0);
    req(0, 32'h13, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 4, 1'b0);
    req(0, 32'h0,  4'hF, 32'h11223344, 32'h0,        1'b0, 3, 1, 0, 1'b0);
    req(0, 32'h0,  4'h4, 32'h00AA0000, 32'h0,        1'b0, 3, 1, 0, 1'b0);
    req(0, 32'h0,  4'h0, 32'h0,        32'h11AA3344, 1'b0, 3, 1, 0, 1'b0);
`ifdef DMEM_CTRL_RANGE_CHECK_EN
    req(0, 32'h1000, 4'h0, 32'h0, 32'h0,        1'b1, 1, 0, 0, 1'b0);
`else
    req(0, 32'h1000, 4'h0, 32'h0, 32'h11AA3344, 1'b0, 3, 1, 0, 1'b0);
`endif
    req(0, 32'h10, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 4, 1'b0);
    req(0, 32'h24, 4'hF, 32'h5A5AA5A5, 32'h0,        1'b0, 3, 1, 9, 1'b1);
    req(0, 32'h24, 4'h0, 32'h0,        32'h5A5AA5A5, 1'b0, 3, 1, 9, 1'b0);

    // dut1: three wait states, window 0x2000..0x203F
    req(1, 32'h2000, 4'hF, 32'hCAFE0001, 32'h0,        1'b0, 6, 1, 0,  1'b0);
    req(1, 32'h203C, 4'hF, 32'h0BAD0F0F, 32'h0,        1'b0, 6, 1, 15, 1'b0);
    req(1, 32'h2000, 4'h0, 32'h0,        32'hCAFE0001, 1'b0, 6, 1, 0,  1'b0);
`ifdef DMEM_CTRL_RANGE_CHECK_EN
    req(1, 32'h1FFC, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
    req(1, 32'h2040, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b0);
`else
    req(1, 32'h1FFC, 4'h0, 32'h0, 32'h0BAD0F0F, 1'b0, 6, 1, 15, 1'b0);
    req(1, 32'h2040, 4'h0, 32'h0, 32'hCAFE0001, 1'b0, 6, 1, 0,  1'b0);
`endif

    // reset pulse while dut1 sits in WAIT; response is dropped
    @(negedge clk);
    v[1] = 1'b1; a[1] = 32'h203C; w[1] = 4'h0; wd[1] = 32'h0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(negedge clk);
    v[1]  = 1'b0;
    rst_n = 1'b1;
    req(1, 32'h203C, 4'h0, 32'h0, 32'h0BAD0F0F, 1'b0, 6, 1, 15, 1'b0);

    repeat (8) @(negedge clk);
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: outstanding dut0 %0d dut1 %0d, required 0 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
